// File: rtl/alu_seq_ctrl_pkg.sv
// alu_seq_ctrl_pkg
//   Shared definitions for the ALU sequencing controller and its neighbours.
//   The ALU opcodes are shared with alu_mod. The flag bit positions apply to
//   flags_in, alu_flags and flags_out. The FSM state encoding is exported so
//   that checkers can decode the state debug output.
package alu_seq_ctrl_pkg;

    // ALU opcodes (same numbering as alu_mod)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_SBC = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_CP  = 3'd7;

    // Flag vector layout {Z,N,H,C}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

    typedef logic [3:0] flags_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC_LO = 3'd1,
        ST_CAP_LO  = 3'd2,
        ST_EXEC_HI = 3'd3,
        ST_CAP_HI  = 3'd4,
        ST_FIN     = 3'd5,
        ST_ERR     = 3'd6
    } state_t;

    // Only ADD and SUB have a 16-bit form (low byte, then ADC/SBC high byte).
    function automatic logic wide_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if
//   Bundles the request side and the external ALU side of alu_seq_ctrl.
//   slave  : the controller itself.
//   master : the requester, plus the external registered ALU.
//
//   Handshake: the requester raises start with op/wide/opa/opb/flags_in
//   valid. The request is taken on the first rising edge where the
//   controller is idle (busy=0). While busy=1, start is ignored and nothing
//   is queued. Completion is a single-cycle done pulse. result and flags_out
//   are valid from that cycle until the next accepted start. err pulses
//   together with done when a wide request names an opcode other than
//   ADD/SUB.
interface alu_seq_ctrl_if;
    import alu_seq_ctrl_pkg::*;

    // request side
    logic        start;
    logic [2:0]  op;
    logic        wide;
    logic [15:0] opa;
    logic [15:0] opb;
    flags_t      flags_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] result;
    flags_t      flags_out;

    // external ALU side
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic        alu_c;
    logic [7:0]  alu_out;
    flags_t      alu_flags;

    modport slave (
        input  start, op, wide, opa, opb, flags_in, alu_out, alu_flags,
        output busy, done, err, result, flags_out, alu_a, alu_b, alu_op, alu_c
    );

    modport master (
        output start, op, wide, opa, opb, flags_in, alu_out, alu_flags,
        input  busy, done, err, result, flags_out, alu_a, alu_b, alu_op, alu_c
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Sequences 8-bit and 16-bit (ADD/SUB only) operations through an external
//   registered 8-bit ALU. A 16-bit operation runs two ALU passes: the low
//   byte, then the high byte using ADC/SBC with the low-byte carry.
//
//   Ports:
//     clock     : system clock; all state updates happen on its rising edge.
//     reset_n   : synchronous, active-low reset.
//     bus       : alu_seq_ctrl_if.slave (request/response and ALU signals).
//     state_dbg : current FSM state, for observation only.
//
//   Timing, counted in cycles after the edge that samples start:
//     narrow op : done in cycle 3.
//     wide op   : done in cycle 5.
//     illegal   : done/err in cycle 1.
//   All outputs are registered. The ALU operands are loaded on the edge that
//   enters an EXEC state and are held at all other times.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    alu_seq_ctrl_if.slave bus,
    output state_t        state_dbg
);

    state_t      state;
    logic [2:0]  op_q;
    logic        wide_q;
    logic [7:0]  opa_hi_q;
    logic [7:0]  opb_hi_q;
    logic        z_in_q;     // incoming Z, preserved by wide ADD
    logic [7:0]  lo_q;       // low-byte result of a wide op

    logic        busy_r;
    logic        done_r;
    logic        err_r;
    logic [15:0] result_r;
    flags_t      flags_r;
    logic [7:0]  alu_a_r;
    logic [7:0]  alu_b_r;
    logic [2:0]  alu_op_r;
    logic        alu_c_r;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            op_q     <= 3'd0;
            wide_q   <= 1'b0;
            opa_hi_q <= 8'h00;
            opb_hi_q <= 8'h00;
            z_in_q   <= 1'b0;
            lo_q     <= 8'h00;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            result_r <= 16'h0000;
            flags_r  <= 4'h0;
            alu_a_r  <= 8'h00;
            alu_b_r  <= 8'h00;
            alu_op_r <= 3'd0;
            alu_c_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        wide_q   <= bus.wide;
                        opa_hi_q <= bus.opa[15:8];
                        opb_hi_q <= bus.opb[15:8];
                        z_in_q   <= bus.flags_in[FLAG_Z];
                        busy_r   <= 1'b1;
                        if (bus.wide && !wide_legal(bus.op)) begin
                            // No ALU pass; the ALU outputs stay untouched.
                            state  <= ST_ERR;
                            done_r <= 1'b1;
                            err_r  <= 1'b1;
                        end else begin
                            // Loaded here so they are valid throughout EXEC_LO.
                            state    <= ST_EXEC_LO;
                            alu_a_r  <= bus.opa[7:0];
                            alu_b_r  <= bus.opb[7:0];
                            alu_op_r <= bus.op;
                            alu_c_r  <= bus.flags_in[FLAG_C];
                        end
                    end
                end
                ST_EXEC_LO: state <= ST_CAP_LO;
                ST_CAP_LO: begin
                    if (wide_q) begin
                        lo_q     <= bus.alu_out;
                        state    <= ST_EXEC_HI;
                        alu_a_r  <= opa_hi_q;
                        alu_b_r  <= opb_hi_q;
                        alu_op_r <= (op_q == OP_ADD) ? OP_ADC : OP_SBC;
                        alu_c_r  <= bus.alu_flags[FLAG_C];
                    end else begin
                        // Narrow result is published on entry to FIN.
                        state    <= ST_FIN;
                        done_r   <= 1'b1;
                        result_r <= {8'h00, bus.alu_out};
                        flags_r  <= bus.alu_flags;
                    end
                end
                ST_EXEC_HI: state <= ST_CAP_HI;
                ST_CAP_HI: begin
                    state    <= ST_FIN;
                    done_r   <= 1'b1;
                    result_r <= {bus.alu_out, lo_q};
                    // H/N/C come from the high byte. ADD keeps the incoming Z.
                    // SUB computes Z over all 16 bits.
                    flags_r  <= {(op_q == OP_ADD) ? z_in_q
                                                  : ((lo_q == 8'h00) && (bus.alu_out == 8'h00)),
                                 bus.alu_flags[FLAG_N],
                                 bus.alu_flags[FLAG_H],
                                 bus.alu_flags[FLAG_C]};
                end
                ST_FIN, ST_ERR: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.result    = result_r;
    assign bus.flags_out = flags_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_op    = alu_op_r;
    assign bus.alu_c     = alu_c_r;
    assign state_dbg     = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Drives alu_seq_ctrl through directed and random requests. A registered
//   8-bit ALU model stands in for alu_mod. Expected {err, flags, result}
//   tuples come from a whole-word arithmetic reference model. Each is queued
//   when a request is issued and popped by an independent monitor on every
//   done pulse.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    logic   clock;
    logic   reset_n;
    state_t state_dbg;

    alu_seq_ctrl_if bus();

    alu_seq_ctrl dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [20:0] exp_q[$];      // {err, flags[3:0], result[15:0]}
    logic [20:0] last_exp = '0; // last published result/flags

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- external ALU model (registered) ----------------
    function automatic logic [11:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op, input logic c);
        logic [8:0] full;
        logic [4:0] nib;
        logic [8:0] cin;
        logic [7:0] res;
        logic [3:0] fl;
        cin = {8'h00, ((op == OP_ADC) || (op == OP_SBC)) ? c : 1'b0};
        full = '0;
        nib  = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                full = {1'b0, a} + {1'b0, b} + cin;
                nib  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + cin[4:0];
                res  = full[7:0];
                fl   = {res == 8'h00, 1'b0, nib[4], full[8]};
            end
            OP_SUB, OP_SBC, OP_CP: begin
                full = {1'b0, a} - {1'b0, b} - cin;
                nib  = {1'b0, a[3:0]} - {1'b0, b[3:0]} - cin[4:0];
                res  = (op == OP_CP) ? a : full[7:0];
                fl   = {full[7:0] == 8'h00, 1'b1, nib[4], full[8]};
            end
            OP_AND: begin res = a & b; fl = {res == 8'h00, 3'b010}; end
            OP_XOR: begin res = a ^ b; fl = {res == 8'h00, 3'b000}; end
            default: begin res = a | b; fl = {res == 8'h00, 3'b000}; end
        endcase
        return {fl, res};
    endfunction

    always @(posedge clock) begin
        {bus.alu_flags, bus.alu_out} <= alu_fn(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c);
    end

    // ---------------- reference model ----------------
    function automatic logic [20:0] ref_model(input int op, input bit wide, input int a,
                                              input int b, input logic [3:0] f,
                                              input logic [20:0] prev);
        int r, cin;
        bit z, n, h, c;
        if (wide && !(op == 0 || op == 2)) return {1'b1, prev[19:0]};
        if (wide) begin
            if (op == 0) begin
                r = a + b; c = (r > 65535); h = ((a & 'hFFF) + (b & 'hFFF)) > 'hFFF;
                n = 0; z = f[3];
            end else begin
                r = a - b; c = (a < b); h = (a & 'hFFF) < (b & 'hFFF);
                n = 1; z = ((r & 'hFFFF) == 0);
            end
            return {1'b0, z, n, h, c, r[15:0]};
        end
        a = a & 255; b = b & 255;
        cin = (op == 1 || op == 3) ? int'(f[0]) : 0;
        case (op)
            0, 1: begin
                r = a + b + cin; c = (r > 255); h = ((a & 15) + (b & 15) + cin) > 15;
                n = 0; r = r & 255; z = (r == 0);
            end
            2, 3, 7: begin
                c = (a < b + cin); h = (a & 15) < ((b & 15) + cin); n = 1;
                r = (a - b - cin) & 255; z = (r == 0);
                if (op == 7) r = a;
            end
            4: begin r = a & b; h = 1; c = 0; n = 0; z = (r == 0); end
            5: begin r = a ^ b; h = 0; c = 0; n = 0; z = (r == 0); end
            default: begin r = a | b; h = 0; c = 0; n = 0; z = (r == 0); end
        endcase
        return {1'b0, z, n, h, c, 8'h00, r[7:0]};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL done_unexpected: got done=1 expected no completion");
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("completion {err,flags,result}",
                      {11'd0, bus.err, bus.flags_out, bus.result}, {11'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.busy !== 1'b0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (bus.busy !== 1'b0) check("idle_timeout busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic randomize_inputs();
        bus.op       = 3'($urandom_range(0, 7));
        bus.wide     = 1'($urandom_range(0, 1));
        bus.opa      = 16'($urandom_range(0, 65535));
        bus.opb      = 16'($urandom_range(0, 65535));
        bus.flags_in = 4'($urandom_range(0, 15));
    endtask

    task automatic do_op(input logic [2:0] op, input bit wide, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] f);
        logic [19:0] alu_snap;
        logic [20:0] e;
        int lat, exp_lat;
        bit illegal;
        wait_idle();
        @(negedge clock);
        alu_snap     = {bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c};
        bus.start    = 1'b1;
        bus.op       = op;
        bus.wide     = wide;
        bus.opa      = a;
        bus.opb      = b;
        bus.flags_in = f;
        illegal = wide && !(op == OP_ADD || op == OP_SUB);
        e = ref_model(int'(op), wide, int'(a), int'(b), f, last_exp);
        last_exp = e;
        exp_q.push_back(e);
        exp_lat = illegal ? 1 : (wide ? 5 : 3);
        lat = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                check("busy_after_accept", 32'(bus.busy), 32'd1);
                if (illegal)
                    check("err_alu_held", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c}),
                          32'(alu_snap));
                else
                    check("exec_lo_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c}),
                          32'({a[7:0], b[7:0], op, f[FLAG_C]}));
                // Later input changes must not disturb the operation in flight.
                bus.start = 1'b0;
                randomize_inputs();
            end
            if (cyc == 3 && wide && !illegal)
                check("exec_hi_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c}),
                      32'({a[15:8], b[15:8], (op == OP_ADD) ? OP_ADC : OP_SBC,
                           (op == OP_ADD) ? (({1'b0, a[7:0]} + {1'b0, b[7:0]}) > 9'd255)
                                          : (a[7:0] < b[7:0])}));
            if (bus.done === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        check("done_latency", 32'(lat), 32'(exp_lat));
        if (illegal) check("err_with_done", 32'(bus.err), 32'(lat == 1));
    endtask

    // start held high: the second request must be taken only in the cycle after done
    task automatic back_to_back();
        logic [20:0] e;
        wait_idle();
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_XOR; bus.wide = 1'b0;
        bus.opa = 16'h00F0; bus.opb = 16'h003C; bus.flags_in = 4'h0;
        e = ref_model(int'(OP_XOR), 1'b0, 'h00F0, 'h003C, 4'h0, last_exp);
        last_exp = e;
        exp_q.push_back(e);
        exp_q.push_back(e);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clock);
            check($sformatf("b2b_done_c%0d", cyc), 32'(bus.done), 32'(cyc == 3 || cyc == 7));
            if (cyc == 4) check("b2b_idle_gap busy", 32'(bus.busy), 32'd0);
            if (cyc == 5) check("b2b_second_accept busy", 32'(bus.busy), 32'd1);
        end
        bus.start = 1'b0;
    endtask

    // reset asserted while the high byte is executing
    task automatic reset_mid_op();
        wait_idle();
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_ADD; bus.wide = 1'b1;
        bus.opa = 16'h1234; bus.opb = 16'h4321; bus.flags_in = 4'h0;
        exp_q.push_back(ref_model(0, 1'b1, 'h1234, 'h4321, 4'h0, last_exp));
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);            // cycle 3: EXEC_HI
        reset_n = 1'b0;
        @(negedge clock);
        exp_q.delete();              // the aborted operation never completes
        last_exp = '0;
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        check("rst_mid done", 32'(bus.done), 32'd0);
        check("rst_mid result", 32'(bus.result), 32'h0000);
        check("rst_mid flags", 32'(bus.flags_out), 32'h0);
        reset_n = 1'b1;
        repeat (6) @(negedge clock); // monitor flags any stray done here
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.wide = 1'b0;
        bus.opa = 16'h0; bus.opb = 16'h0; bus.flags_in = 4'h0;
        repeat (3) @(negedge clock);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst done/err", 32'({bus.done, bus.err}), 32'd0);
        check("rst result", 32'(bus.result), 32'h0000);
        check("rst flags", 32'(bus.flags_out), 32'h0);
        check("rst alu", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_c}), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        do_op(OP_ADD, 1'b0, 16'h0004, 16'h00FF, 4'h0);   // 0x0003, H C
        do_op(OP_ADD, 1'b1, 16'h12FF, 16'h0001, 4'h8);   // 0x1300, Z preserved
        do_op(OP_SUB, 1'b1, 16'h0100, 16'h0001, 4'h0);   // 0x00FF, N
        do_op(OP_AND, 1'b1, 16'h5555, 16'h00FF, 4'hF);   // illegal: err, outputs held
        do_op(OP_SUB, 1'b1, 16'h1234, 16'h1234, 4'h0);   // wide Z=1
        do_op(OP_CP,  1'b0, 16'h0042, 16'h0042, 4'h0);   // CP keeps A
        back_to_back();

        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            bit wide;
            op = 3'($urandom_range(0, 7));
            wide = ($urandom_range(0, 2) == 0);
            if (wide && $urandom_range(0, 3) != 0) op = ($urandom_range(0, 1) == 0) ? OP_ADD : OP_SUB;
            do_op(op, wide, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                  4'($urandom_range(0, 15)));
        end

        reset_mid_op();
        do_op(OP_OR, 1'b1, 16'hAAAA, 16'h5555, 4'h0);    // err right after reset: result stays 0
        do_op(OP_SBC, 1'b0, 16'h0010, 16'h0001, 4'h1);

        wait_idle();
        repeat (4) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        n_checks++;
        n_errors++;
        $display("FAIL global_timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "timeout");
    end

endmodule
